// File: rtl/pwm_decoder_if.sv
// pwm_decoder_if: pulse input and decoded result bundle for pwm_decoder.
// Ports: pwm_in (source -> decoder); width, width_valid, pulse_error,
//   signal_ok (decoder -> consumer). master = source/consumer side,
//   slave = decoder side.
interface pwm_decoder_if;
   logic       pwm_in;
   logic [7:0] width;
   logic       width_valid;
   logic       pulse_error;
   logic       signal_ok;

   modport master (
      output pwm_in,
      input  width,
      input  width_valid,
      input  pulse_error,
      input  signal_ok
   );

   modport slave (
      input  pwm_in,
      output width,
      output width_valid,
      output pulse_error,
      output signal_ok
   );
endinterface

// File: rtl/pwm_decoder.sv
// pwm_decoder: measures RC servo/PWM high time and converts it to an
// 8-bit code (1ms -> 0, 2ms -> 255).
// Ports: clk_255kHz (tick clock), reset (sync, active-high),
//   bus.pwm_in (async pulse in), bus.width (last accepted code),
//   bus.width_valid (1-cycle update strobe), bus.pulse_error
//   (1-cycle out-of-range strobe), bus.signal_ok (pulses arriving).
module pwm_decoder #(
   parameter int OFFSET_TICKS  = 255,
   parameter int MIN_TICKS     = 204,
   parameter int MAX_TICKS     = 561,
   parameter int TIMEOUT_TICKS = 7650
) (
   input logic         clk_255kHz,
   input logic         reset,
   pwm_decoder_if.slave bus
);

   localparam int CW = 13;

   localparam logic [CW-1:0] OFF_C = CW'(OFFSET_TICKS);
   localparam logic [CW-1:0] MIN_C = CW'(MIN_TICKS);
   localparam logic [CW-1:0] MAX_C = CW'(MAX_TICKS);
   localparam logic [CW-1:0] HSAT  = CW'(MAX_TICKS + 1);
   localparam logic [CW-1:0] TOUT  = CW'(TIMEOUT_TICKS);
   localparam logic [CW-1:0] CODE_MAX = CW'(255);

   typedef enum logic [1:0] {
      IDLE,
      HIGH,
      LOW
   } state_t;

   state_t state;

   logic          s1;
   logic          s;
   logic          s_d;
   logic [2:0]    primed;

   logic [CW-1:0] hi_cnt;
   logic [CW-1:0] per_cnt;

   logic          rise;
   logic          fall;
   logic          timeout;
   logic          in_range;

   logic [CW-1:0] excess;
   logic [7:0]    code;

   logic [7:0]    width_q;
   logic          width_valid_q;
   logic          pulse_error_q;
   logic          signal_ok_q;

   // primed[2] marks that s_d holds a real post-reset sample, so a
   // pulse already high when reset releases never looks like a rise.
   assign rise    = s & ~s_d & primed[2];
   assign fall    = ~s & s_d & primed[2];
   assign timeout = (per_cnt == TOUT);

   assign in_range = (hi_cnt >= MIN_C) && (hi_cnt <= MAX_C);

   // Compare before subtracting so short pulses clamp to 0
   // instead of wrapping.
   always_comb begin
      excess = '0;
      code   = '0;
      if (hi_cnt > OFF_C) begin
         excess = hi_cnt - OFF_C;
         if (excess > CODE_MAX) begin
            code = 8'hFF;
         end else begin
            code = excess[7:0];
         end
      end
   end

   always_ff @(posedge clk_255kHz) begin
      if (reset) begin
         s1     <= 1'b0;
         s      <= 1'b0;
         s_d    <= 1'b0;
         primed <= '0;
      end else begin
         s1     <= bus.pwm_in;
         s      <= s1;
         s_d    <= s;
         primed <= {primed[1:0], 1'b1};
      end
   end

   always_ff @(posedge clk_255kHz) begin
      if (reset) begin
         hi_cnt  <= '0;
         per_cnt <= '0;
      end else begin
         if (rise) begin
            per_cnt <= '0;
         end else if (per_cnt != TOUT) begin
            per_cnt <= per_cnt + 1'b1;
         end

         if (rise) begin
            hi_cnt <= CW'(1);
         end else if (state == HIGH && s && hi_cnt != HSAT) begin
            hi_cnt <= hi_cnt + 1'b1;
         end
      end
   end

   // A rise in the same cycle as a timeout wins: it restarts the
   // period counter, so a pulse after a long silence is measured.
   always_ff @(posedge clk_255kHz) begin
      if (reset) begin
         state         <= IDLE;
         width_q       <= '0;
         width_valid_q <= 1'b0;
         pulse_error_q <= 1'b0;
         signal_ok_q   <= 1'b0;
      end else begin
         width_valid_q <= 1'b0;
         pulse_error_q <= 1'b0;
         if (timeout && !rise) begin
            state       <= IDLE;
            signal_ok_q <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (rise) begin
                     state <= HIGH;
                  end
               end
               HIGH: begin
                  if (fall) begin
                     state <= LOW;
                     if (in_range) begin
                        width_q       <= code;
                        width_valid_q <= 1'b1;
                        signal_ok_q   <= 1'b1;
                     end else begin
                        pulse_error_q <= 1'b1;
                     end
                  end
               end
               LOW: begin
                  if (rise) begin
                     state <= HIGH;
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

   assign bus.width       = width_q;
   assign bus.width_valid = width_valid_q;
   assign bus.pulse_error = pulse_error_q;
   assign bus.signal_ok   = signal_ok_q;

endmodule
